// File: rtl/da_sample_pacer.sv
// da_sample_pacer
// Upstream feeder for the DAC serializer. Host codes are queued in a small
// FIFO and released one per sample period, set by a programmable divider.
// Each released code is offered on a valid/ready handshake. Overflow, underrun
// and late-sample events are recorded in sticky flags.
module da_sample_pacer #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 4,
    parameter int DIV_W  = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              enable,
    input  logic [DIV_W-1:0]  rate_div,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_flags,
    output logic [DATA_W-1:0] da_data,
    output logic              da_valid,
    input  logic              da_ready,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underrun,
    output logic              late
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_LVL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Divider
    logic [DIV_W-1:0]  cnt_r;
    logic              wrap_s;
    logic              tick_s;

    // FIFO
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   level_r;
    logic [ADDR_W:0]   level_nxt_s;
    logic              full_r;
    logic              empty_r;
    logic              push_s;
    logic              pop_s;
    logic [DATA_W-1:0] head_s;

    // Output stage
    state_t            state_r;
    state_t            state_nxt_s;
    logic [DATA_W-1:0] da_data_r;
    logic              da_valid_r;
    logic              handshake_s;
    logic              underrun_set_s;
    logic              late_set_s;
    logic              overflow_set_s;

    // Sticky flags
    logic              overflow_r;
    logic              underrun_r;
    logic              late_r;

    // A shrinking rate_div must still produce a tick, so compare with >=
    assign wrap_s      = (cnt_r >= rate_div);
    assign tick_s      = enable & wrap_s;
    assign handshake_s = da_valid_r & da_ready;

    // Writes are refused while full, even if a pop frees a slot this cycle
    assign push_s         = wr_en & ~full_r;
    assign overflow_set_s = wr_en & full_r;
    assign head_s         = mem_r[rd_ptr_r];

    // Sample-period counter: held at zero while pacing is disabled
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_r <= {DIV_W{1'b0}};
        end else if (!enable) begin
            cnt_r <= {DIV_W{1'b0}};
        end else if (wrap_s) begin
            cnt_r <= {DIV_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + DIV_W'(1);
        end
    end

    // FIFO storage array; contents are don't-care until written
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Next FIFO occupancy from this cycle's push/pop pair
    always_comb begin
        level_nxt_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + (ADDR_W + 1)'(1);
            2'b01:   level_nxt_s = level_r - (ADDR_W + 1)'(1);
            default: level_nxt_s = level_r;
        endcase
    end

    // FIFO pointers and registered occupancy/status; pointers wrap naturally
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_r <= {ADDR_W{1'b0}};
            rd_ptr_r <= {ADDR_W{1'b0}};
            level_r  <= {(ADDR_W + 1){1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
            end
            level_r <= level_nxt_s;
            full_r  <= (level_nxt_s == DEPTH_LVL);
            empty_r <= (level_nxt_s == {(ADDR_W + 1){1'b0}});
        end
    end

    // Output FSM state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Output FSM next state: a tick arms HOLD, an accepted transfer returns
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (tick_s) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (handshake_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output FSM actions: pop on an idle tick, flag empty or busy ticks
    always_comb begin
        pop_s          = 1'b0;
        underrun_set_s = 1'b0;
        late_set_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (tick_s) begin
                    if (!empty_r) begin
                        pop_s = 1'b1;
                    end else begin
                        underrun_set_s = 1'b1;
                    end
                end else begin
                    pop_s = 1'b0;
                end
            end
            ST_HOLD: begin
                if (tick_s) begin
                    late_set_s = 1'b1;
                end else begin
                    late_set_s = 1'b0;
                end
            end
            default: begin
                pop_s = 1'b0;
            end
        endcase
    end

    // Presented sample: new code on pop, otherwise hold (underrun re-presents)
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            da_data_r  <= {DATA_W{1'b0}};
            da_valid_r <= 1'b0;
        end else begin
            da_valid_r <= (state_nxt_s == ST_HOLD);
            if (pop_s) begin
                da_data_r <= head_s;
            end else begin
                da_data_r <= da_data_r;
            end
        end
    end

    // Sticky flags: a new event takes priority over a coincident clear
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            overflow_r <= 1'b0;
            underrun_r <= 1'b0;
            late_r     <= 1'b0;
        end else begin
            overflow_r <= overflow_set_s | (overflow_r & ~clr_flags);
            underrun_r <= underrun_set_s | (underrun_r & ~clr_flags);
            late_r     <= late_set_s     | (late_r     & ~clr_flags);
        end
    end

    assign da_data  = da_data_r;
    assign da_valid = da_valid_r;
    assign full     = full_r;
    assign empty    = empty_r;
    assign level    = level_r;
    assign overflow = overflow_r;
    assign underrun = underrun_r;
    assign late     = late_r;

endmodule
